// File: rtl/ntt_axil_ctrl_slave.sv
// ntt_axil_ctrl_slave
//   AXI4-Lite responder for the NTT control block. Decodes CTRL/STATUS/IE/ID,
//   issues a one-cycle start pulse and mode bit to the NTT core, tracks
//   busy/done/error and drives the level done-interrupt to the PS.
// Ports:
//   ACLK, ARESETn          clock, synchronous active-low reset
//   S_AXI_AW*/W*/B*        AXI4-Lite write address, data and response channels
//   S_AXI_AR*/R*           AXI4-Lite read address and data channels
//   ntt_start / ntt_mode   start pulse and NTT(0)/iNTT(1) select to the core
//   ntt_done               one-cycle completion pulse from the core
//   irq                    registered done & IE level interrupt
`timescale 1ns/1ps
module ntt_axil_ctrl_slave #(
    parameter int          C_ADDR_WIDTH = 4,
    parameter int          C_DATA_WIDTH = 32,
    parameter logic [31:0] C_IP_VERSION = 32'h0001_0000
) (
    input  logic                      ACLK,
    input  logic                      ARESETn,
    input  logic [C_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic                      S_AXI_AWVALID,
    output logic                      S_AXI_AWREADY,
    input  logic [C_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                      S_AXI_WVALID,
    output logic                      S_AXI_WREADY,
    output logic [1:0]                S_AXI_BRESP,
    output logic                      S_AXI_BVALID,
    input  logic                      S_AXI_BREADY,
    input  logic [C_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic                      S_AXI_ARVALID,
    output logic                      S_AXI_ARREADY,
    output logic [C_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                S_AXI_RRESP,
    output logic                      S_AXI_RVALID,
    input  logic                      S_AXI_RREADY,
    output logic                      ntt_start,
    output logic                      ntt_mode,
    input  logic                      ntt_done,
    output logic                      irq
);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        REG_CTRL   = 2'd0,
        REG_STATUS = 2'd1,
        REG_IE     = 2'd2,
        REG_ID     = 2'd3
    } reg_idx_e;

    // Write channel holding registers
    logic                    aw_valid_q, aw_valid_d;
    logic [C_ADDR_WIDTH-1:0] aw_addr_q,  aw_addr_d;
    logic                    w_valid_q,  w_valid_d;
    logic [2:0]              w_data_q,   w_data_d;
    logic                    w_strb0_q,  w_strb0_d;
    logic                    bvalid_q,   bvalid_d;
    logic [1:0]              bresp_q,    bresp_d;
    // Read channel
    logic                    rvalid_q,   rvalid_d;
    logic [C_DATA_WIDTH-1:0] rdata_q,    rdata_d;
    logic [1:0]              rresp_q,    rresp_d;
    // Control/status state
    logic mode_q,  mode_d;
    logic busy_q,  busy_d;
    logic done_q,  done_d;
    logic error_q, error_d;
    logic ie_q,    ie_d;
    logic start_q, start_d;
    logic irq_q,   irq_d;
    // Holds all READY outputs low until the first edge after reset releases
    logic init_q;

    logic                    commit;
    logic                    aw_mapped, ar_mapped;
    reg_idx_e                aw_idx, ar_idx;
    logic [C_DATA_WIDTH-1:0] rd_val;
    logic                    unused_bits;

    assign unused_bits = ^{S_AXI_WDATA[C_DATA_WIDTH-1:3], S_AXI_WSTRB[C_DATA_WIDTH/8-1:1]};

    assign S_AXI_AWREADY = init_q & ~aw_valid_q & ~bvalid_q;
    assign S_AXI_WREADY  = init_q & ~w_valid_q  & ~bvalid_q;
    assign S_AXI_ARREADY = init_q & ~rvalid_q;
    assign S_AXI_BVALID  = bvalid_q;
    assign S_AXI_BRESP   = bresp_q;
    assign S_AXI_RVALID  = rvalid_q;
    assign S_AXI_RDATA   = rdata_q;
    assign S_AXI_RRESP   = rresp_q;
    assign ntt_start     = start_q;
    assign ntt_mode      = mode_q;
    assign irq           = irq_q;

    // Only the four words at offsets 0x0..0xC exist; any higher decoded bit is a hole
    assign aw_mapped = (aw_addr_q >> 4) == '0;
    assign ar_mapped = (S_AXI_ARADDR >> 4) == '0;
    assign aw_idx    = reg_idx_e'(aw_addr_q[3:2]);
    assign ar_idx    = reg_idx_e'(S_AXI_ARADDR[3:2]);
    assign commit    = aw_valid_q & w_valid_q & ~bvalid_q;

    always_comb begin
        rd_val = '0;
        if (ar_mapped) begin
            unique case (ar_idx)
                REG_CTRL:   rd_val[1]   = mode_q;
                REG_STATUS: rd_val[2:0] = {error_q, done_q, busy_q};
                REG_IE:     rd_val[0]   = ie_q;
                REG_ID:     rd_val      = C_IP_VERSION[C_DATA_WIDTH-1:0];
            endcase
        end
    end

    // NOTE: every variable gets its default before any branch so no latch is inferred.
    always_comb begin
        logic ack, err_evt, err_clr;
        aw_valid_d = aw_valid_q;
        aw_addr_d  = aw_addr_q;
        w_valid_d  = w_valid_q;
        w_data_d   = w_data_q;
        w_strb0_d  = w_strb0_q;
        bvalid_d   = bvalid_q;
        bresp_d    = bresp_q;
        rvalid_d   = rvalid_q;
        rdata_d    = rdata_q;
        rresp_d    = rresp_q;
        mode_d     = mode_q;
        busy_d     = busy_q;
        done_d     = done_q;
        error_d    = error_q;
        ie_d       = ie_q;
        start_d    = 1'b0;
        ack        = 1'b0;
        err_evt    = 1'b0;
        err_clr    = 1'b0;

        if (S_AXI_AWVALID && S_AXI_AWREADY) begin
            aw_valid_d = 1'b1;
            aw_addr_d  = S_AXI_AWADDR;
        end
        if (S_AXI_WVALID && S_AXI_WREADY) begin
            w_valid_d = 1'b1;
            w_data_d  = S_AXI_WDATA[2:0];
            w_strb0_d = S_AXI_WSTRB[0];
        end
        if (bvalid_q && S_AXI_BREADY) bvalid_d = 1'b0;

        if (commit) begin
            aw_valid_d = 1'b0;
            w_valid_d  = 1'b0;
            bvalid_d   = 1'b1;
            bresp_d    = aw_mapped ? RESP_OKAY : RESP_SLVERR;
            if (aw_mapped && w_strb0_q) begin
                unique case (aw_idx)
                    REG_CTRL: begin
                        if (w_data_q[0]) begin
                            if (busy_q) begin
                                err_evt = 1'b1;
                            end else begin
                                mode_d  = w_data_q[1];
                                busy_d  = 1'b1;
                                done_d  = 1'b0;
                                start_d = 1'b1;
                            end
                        end else if (!busy_q) begin
                            // Idle CTRL write with START=0 is the done acknowledge
                            mode_d = w_data_q[1];
                            ack    = 1'b1;
                        end
                    end
                    REG_STATUS: err_clr = w_data_q[2];
                    REG_IE:     ie_d    = w_data_q[0];
                    REG_ID:     ;
                endcase
            end
        end

        // Completion takes priority over an acknowledge on the same edge
        if (ntt_done && busy_q) begin
            busy_d = 1'b0;
            done_d = 1'b1;
        end else if (ack) begin
            done_d = 1'b0;
        end

        // A new error event outranks a simultaneous write-1-to-clear
        if (err_clr) error_d = 1'b0;
        if (err_evt) error_d = 1'b1;

        irq_d = done_q & ie_q;

        if (rvalid_q && S_AXI_RREADY) rvalid_d = 1'b0;
        if (S_AXI_ARVALID && S_AXI_ARREADY) begin
            rvalid_d = 1'b1;
            rdata_d  = rd_val;
            rresp_d  = ar_mapped ? RESP_OKAY : RESP_SLVERR;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            aw_valid_q <= 1'b0;
            aw_addr_q  <= '0;
            w_valid_q  <= 1'b0;
            w_data_q   <= '0;
            w_strb0_q  <= 1'b0;
            bvalid_q   <= 1'b0;
            bresp_q    <= RESP_OKAY;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
            rresp_q    <= RESP_OKAY;
            mode_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            ie_q       <= 1'b1;
            start_q    <= 1'b0;
            irq_q      <= 1'b0;
            init_q     <= 1'b0;
        end else begin
            aw_valid_q <= aw_valid_d;
            aw_addr_q  <= aw_addr_d;
            w_valid_q  <= w_valid_d;
            w_data_q   <= w_data_d;
            w_strb0_q  <= w_strb0_d;
            bvalid_q   <= bvalid_d;
            bresp_q    <= bresp_d;
            rvalid_q   <= rvalid_d;
            rdata_q    <= rdata_d;
            rresp_q    <= rresp_d;
            mode_q     <= mode_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            error_q    <= error_d;
            ie_q       <= ie_d;
            start_q    <= start_d;
            irq_q      <= irq_d;
            init_q     <= 1'b1;
        end
    end

endmodule
